// File: rtl/regfile_sb.sv
// regfile_sb -- register file with a per-register busy scoreboard.
//
// DEPTH = 2**ADDR_W registers of DATA_W bits. There is one write port, two
// read ports with one cycle of latency, and a reserve port that marks a
// register as awaiting a result. A write stores the data and clears the
// register's busy bit. Reads are write-first: each read port sees this
// cycle's write and reservation when the addresses match. With ZERO_REG=1,
// register 0 reads as zero and is never busy.
//
// Ports
//   clk                 rising-edge clock
//   rst                 asynchronous active-high reset; clears all state
//   wr_en/addr/data     write strobe, address, data
//   rd0_addr, rd1_addr  read addresses
//   rd0_data, rd1_data  registered read data
//   rd0_busy, rd1_busy  registered busy flag of the addressed register
//   rsv_en, rsv_addr    reserve strobe and address
//   busy_cnt            registered count of busy registers (0..DEPTH)
module regfile_sb #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd0_addr,
   input  logic [ADDR_W-1:0] rd1_addr,
   output logic [DATA_W-1:0] rd0_data,
   output logic [DATA_W-1:0] rd1_data,
   output logic              rd0_busy,
   output logic              rd1_busy,
   input  logic              rsv_en,
   input  logic [ADDR_W-1:0] rsv_addr,
   output logic [ADDR_W:0]   busy_cnt
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] regs [DEPTH];
   logic [DEPTH-1:0]  busy;
   logic [DEPTH-1:0]  busy_nxt;
   logic              wr_ok;
   logic              rsv_ok;
   logic [DATA_W-1:0] rd0_data_nxt;
   logic [DATA_W-1:0] rd1_data_nxt;
   logic              rd0_busy_nxt;
   logic              rd1_busy_nxt;

   // Returns 1 when the address names the hardwired zero register.
   function automatic logic is_zero(input logic [ADDR_W-1:0] a);
      return (ZERO_REG != 0) && (a == '0);
   endfunction

   function automatic logic [ADDR_W:0] popcount(input logic [DEPTH-1:0] v);
      logic [ADDR_W:0] c;
      c = '0;
      for (int i = 0; i < DEPTH; i++) begin
         c = c + {{ADDR_W{1'b0}}, v[i]};
      end
      return c;
   endfunction

   // Next-state busy vector. The reservation is applied after the write
   // clear, so a reserve and a write to the same register leave it busy.
   always_comb begin
      wr_ok    = wr_en && !is_zero(wr_addr);
      rsv_ok   = rsv_en && !is_zero(rsv_addr);
      busy_nxt = busy;
      if (wr_ok) begin
         busy_nxt[wr_addr] = 1'b0;
      end
      if (rsv_ok) begin
         busy_nxt[rsv_addr] = 1'b1;
      end
   end

   // Write-first read muxes. A write to address 0 is already dropped in
   // wr_ok when register 0 is hardwired, so no bypass reaches it.
   always_comb begin
      rd0_data_nxt = regs[rd0_addr];
      if (wr_ok && (wr_addr == rd0_addr)) begin
         rd0_data_nxt = wr_data;
      end
      if (is_zero(rd0_addr)) begin
         rd0_data_nxt = '0;
      end
      rd0_busy_nxt = busy_nxt[rd0_addr] && !is_zero(rd0_addr);

      rd1_data_nxt = regs[rd1_addr];
      if (wr_ok && (wr_addr == rd1_addr)) begin
         rd1_data_nxt = wr_data;
      end
      if (is_zero(rd1_addr)) begin
         rd1_data_nxt = '0;
      end
      rd1_busy_nxt = busy_nxt[rd1_addr] && !is_zero(rd1_addr);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
         busy     <= '0;
         rd0_data <= '0;
         rd1_data <= '0;
         rd0_busy <= 1'b0;
         rd1_busy <= 1'b0;
         busy_cnt <= '0;
      end else begin
         if (wr_ok) begin
            regs[wr_addr] <= wr_data;
         end
         busy     <= busy_nxt;
         rd0_data <= rd0_data_nxt;
         rd1_data <= rd1_data_nxt;
         rd0_busy <= rd0_busy_nxt;
         rd1_busy <= rd1_busy_nxt;
         busy_cnt <= popcount(busy_nxt);
      end
   end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed testbench for regfile_sb. Three instances share one stimulus:
//   u0: defaults (32 bit, 32 regs, register 0 hardwired to zero)
//   u1: 32 bit, 32 regs, register 0 ordinary
//   u2: 16 bit, 8 regs, register 0 ordinary (uses low address/data bits)
module tb_regfile_sb;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr_en = 1'b0;
   logic [4:0]  wr_addr = '0;
   logic [31:0] wr_data = '0;
   logic        rsv_en = 1'b0;
   logic [4:0]  rsv_addr = '0;
   logic [4:0]  rd0_addr = '0;
   logic [4:0]  rd1_addr = '0;

   logic [31:0] rd0_data0, rd1_data0, rd0_data1, rd1_data1;
   logic        rd0_busy0, rd1_busy0, rd0_busy1, rd1_busy1;
   logic [5:0]  busy_cnt0, busy_cnt1;
   logic [15:0] rd0_data2, rd1_data2;
   logic        rd0_busy2, rd1_busy2;
   logic [3:0]  busy_cnt2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   regfile_sb u0 (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd0_addr(rd0_addr), .rd1_addr(rd1_addr), .rd0_data(rd0_data0), .rd1_data(rd1_data0),
      .rd0_busy(rd0_busy0), .rd1_busy(rd1_busy0), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
      .busy_cnt(busy_cnt0)
   );

   regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0)) u1 (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd0_addr(rd0_addr), .rd1_addr(rd1_addr), .rd0_data(rd0_data1), .rd1_data(rd1_data1),
      .rd0_busy(rd0_busy1), .rd1_busy(rd1_busy1), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
      .busy_cnt(busy_cnt1)
   );

   regfile_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0)) u2 (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr[2:0]), .wr_data(wr_data[15:0]),
      .rd0_addr(rd0_addr[2:0]), .rd1_addr(rd1_addr[2:0]), .rd0_data(rd0_data2),
      .rd1_data(rd1_data2), .rd0_busy(rd0_busy2), .rd1_busy(rd1_busy2), .rsv_en(rsv_en),
      .rsv_addr(rsv_addr[2:0]), .busy_cnt(busy_cnt2)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Apply one cycle of inputs at the falling edge.
   task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic re, input logic [4:0] ra,
                        input logic [4:0] a0, input logic [4:0] a1);
      @(negedge clk);
      wr_en    = we;
      wr_addr  = wa;
      wr_data  = wd;
      rsv_en   = re;
      rsv_addr = ra;
      rd0_addr = a0;
      rd1_addr = a1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic        re;
      logic [4:0]  ra;
      logic [4:0]  a0;
      logic [4:0]  a1;
      logic [31:0] d0;    // u0 expectations
      logic [31:0] d1;
      logic        b0;
      logic        b1;
      logic [5:0]  cnt;
      logic [31:0] zd0;   // u1 expectations (u2 uses the low bits)
      logic        zb0;
      logic [5:0]  zcnt;
   } vec_t;

   vec_t vecs [11];

   initial begin
      vecs[0]  = '{1'b1, 5'd5, 32'h1234,     1'b0, 5'd0, 5'd5, 5'd0,
                   32'h1234, 32'h0, 1'b0, 1'b0, 6'd0, 32'h1234, 1'b0, 6'd0};
      vecs[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 5'd5,
                   32'h0, 32'h1234, 1'b0, 1'b0, 6'd0, 32'h0, 1'b0, 6'd0};
      vecs[2]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 5'd3, 5'd7,
                   32'h0, 32'h0, 1'b1, 1'b0, 6'd1, 32'h0, 1'b1, 6'd1};
      vecs[3]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 5'd3, 5'd7,
                   32'h0, 32'h0, 1'b1, 1'b1, 6'd2, 32'h0, 1'b1, 6'd2};
      vecs[4]  = '{1'b1, 5'd3, 32'hAAAA0003, 1'b0, 5'd0, 5'd3, 5'd7,
                   32'hAAAA0003, 32'h0, 1'b0, 1'b1, 6'd1, 32'hAAAA0003, 1'b0, 6'd1};
      vecs[5]  = '{1'b1, 5'd7, 32'h77,       1'b1, 5'd7, 5'd7, 5'd7,
                   32'h77, 32'h77, 1'b1, 1'b1, 6'd1, 32'h77, 1'b1, 6'd1};
      vecs[6]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 5'd7, 5'd3,
                   32'h77, 32'hAAAA0003, 1'b1, 1'b0, 6'd1, 32'h77, 1'b1, 6'd1};
      vecs[7]  = '{1'b1, 5'd9, 32'h99,       1'b0, 5'd0, 5'd9, 5'd7,
                   32'h99, 32'h77, 1'b0, 1'b1, 6'd1, 32'h99, 1'b0, 6'd1};
      vecs[8]  = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0, 5'd0,
                   32'h0, 32'h0, 1'b0, 1'b0, 6'd1, 32'hFFFFFFFF, 1'b1, 6'd2};
      vecs[9]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 5'd5,
                   32'h0, 32'h1234, 1'b0, 1'b0, 6'd1, 32'hFFFFFFFF, 1'b1, 6'd2};
      vecs[10] = '{1'b1, 5'd7, 32'h7070,     1'b0, 5'd0, 5'd7, 5'd0,
                   32'h7070, 32'h0, 1'b0, 1'b0, 6'd0, 32'h7070, 1'b0, 6'd1};

      // Reset state while rst is held.
      tick();
      tick();
      chk("rst_rd0_data", rd0_data0, 32'h0);
      chk("rst_rd1_data", rd1_data0, 32'h0);
      chk("rst_rd0_busy", {31'h0, rd0_busy0}, 32'h0);
      chk("rst_rd1_busy", {31'h0, rd1_busy0}, 32'h0);
      chk("rst_busy_cnt", {26'h0, busy_cnt0}, 32'h0);
      chk("rst_u2_cnt", {28'h0, busy_cnt2}, 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // Table vectors: bypass, scoreboard, zero register.
      for (int i = 0; i < 11; i++) begin
         drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].re, vecs[i].ra,
               vecs[i].a0, vecs[i].a1);
         tick();
         chk($sformatf("v%0d_rd0_data", i), rd0_data0, vecs[i].d0);
         chk($sformatf("v%0d_rd1_data", i), rd1_data0, vecs[i].d1);
         chk($sformatf("v%0d_rd0_busy", i), {31'h0, rd0_busy0}, {31'h0, vecs[i].b0});
         chk($sformatf("v%0d_rd1_busy", i), {31'h0, rd1_busy0}, {31'h0, vecs[i].b1});
         chk($sformatf("v%0d_busy_cnt", i), {26'h0, busy_cnt0}, {26'h0, vecs[i].cnt});
         chk($sformatf("v%0d_z_rd0_data", i), rd0_data1, vecs[i].zd0);
         chk($sformatf("v%0d_z_rd0_busy", i), {31'h0, rd0_busy1}, {31'h0, vecs[i].zb0});
         chk($sformatf("v%0d_z_busy_cnt", i), {26'h0, busy_cnt1}, {26'h0, vecs[i].zcnt});
         chk($sformatf("v%0d_n_rd0_data", i), {16'h0, rd0_data2}, {16'h0, vecs[i].zd0[15:0]});
         chk($sformatf("v%0d_n_busy_cnt", i), {28'h0, busy_cnt2}, {28'h0, vecs[i].zcnt[3:0]});
      end

      // Fill the scoreboard: reserve every nonzero register.
      for (int a = 1; a < 32; a++) begin
         drive(1'b0, 5'd0, 32'h0, 1'b1, 5'(a), 5'd0, 5'd0);
      end
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd31);
      tick();
      chk("full_cnt", {26'h0, busy_cnt0}, 32'd31);
      chk("full_z_cnt", {26'h0, busy_cnt1}, 32'd32);
      chk("full_n_cnt", {28'h0, busy_cnt2}, 32'd8);
      chk("full_rd0_busy", {31'h0, rd0_busy0}, 32'h1);
      chk("full_rd1_busy", {31'h0, rd1_busy0}, 32'h1);

      // Reserving an already-busy register changes nothing.
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd4, 5'd0);
      tick();
      chk("rsv_again_cnt", {26'h0, busy_cnt0}, 32'd31);
      chk("rsv_again_n_cnt", {28'h0, busy_cnt2}, 32'd8);
      chk("rsv_again_busy", {31'h0, rd0_busy0}, 32'h1);

      // Write every register; all busy bits clear.
      for (int a = 0; a < 32; a++) begin
         drive(1'b1, 5'(a), {4{8'(a)}}, 1'b0, 5'd0, 5'd0, 5'd0);
      end
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd31, 5'd1);
      tick();
      chk("wr_all_cnt", {26'h0, busy_cnt0}, 32'd0);
      chk("wr_all_z_cnt", {26'h0, busy_cnt1}, 32'd0);
      chk("wr_all_n_cnt", {28'h0, busy_cnt2}, 32'd0);
      chk("wr_all_rd31", rd0_data0, 32'h1F1F1F1F);
      chk("wr_all_rd1", rd1_data0, 32'h01010101);
      chk("wr_all_n_rd7", {16'h0, rd0_data2}, 32'h1F1F);
      chk("wr_all_n_rd1", {16'h0, rd1_data2}, 32'h1919);

      // 16-bit instance: write reg 7, read it back from storage.
      drive(1'b1, 5'd7, 32'h0000A5A5, 1'b0, 5'd0, 5'd0, 5'd0);
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd7);
      tick();
      chk("n_rd0_a5a5", {16'h0, rd0_data2}, 32'hA5A5);
      chk("n_rd1_a5a5", {16'h0, rd1_data2}, 32'hA5A5);
      chk("rd0_a5a5", rd0_data0, 32'h0000A5A5);

      // Reset mid-operation: pending reservation and last register cleared.
      drive(1'b1, 5'd31, 32'hDEADBEEF, 1'b1, 5'd3, 5'd31, 5'd3);
      tick();
      chk("pre_rst_rd31", rd0_data0, 32'hDEADBEEF);
      chk("pre_rst_busy3", {31'h0, rd1_busy0}, 32'h1);
      chk("pre_rst_cnt", {26'h0, busy_cnt0}, 32'd1);
      @(negedge clk);
      rst = 1'b1;
      wr_en = 1'b1;
      wr_addr = 5'd31;
      wr_data = 32'h1;
      rsv_en = 1'b1;
      rsv_addr = 5'd5;
      #1;
      chk("async_rst_rd0", rd0_data0, 32'h0);
      chk("async_rst_busy1", {31'h0, rd1_busy0}, 32'h0);
      chk("async_rst_cnt", {26'h0, busy_cnt0}, 32'd0);
      tick();
      @(negedge clk);
      rst = 1'b0;
      wr_en = 1'b0;
      rsv_en = 1'b0;
      rd0_addr = 5'd31;
      rd1_addr = 5'd5;
      tick();
      chk("post_rst_rd31", rd0_data0, 32'h0);
      chk("post_rst_rd5", rd1_data0, 32'h0);
      chk("post_rst_busy5", {31'h0, rd1_busy0}, 32'h0);
      chk("post_rst_cnt", {26'h0, busy_cnt0}, 32'd0);
      chk("post_rst_n_rd7", {16'h0, rd0_data2}, 32'h0);
      chk("post_rst_n_cnt", {28'h0, busy_cnt2}, 32'd0);

      // Normal operation resumes right after reset.
      drive(1'b1, 5'd12, 32'hCAFEF00D, 1'b0, 5'd0, 5'd0, 5'd0);
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd12, 5'd12);
      tick();
      chk("resume_rd0", rd0_data0, 32'hCAFEF00D);
      chk("resume_rd1", rd1_data0, 32'hCAFEF00D);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
